matrix_scan: RTL

MATRIX_SCAN -- requirements
Module: matrix_scan

---
 rtl/matrix_scan_pkg.sv | 27 ++
 rtl/matrix_scan_timer.sv | 33 +++
 rtl/matrix_scan.sv | 96 +++++++++
 3 files changed

// File: rtl/matrix_scan_pkg.sv
// ============================================================================
// matrix_scan_pkg : shared constants, scan-state enum and row-select helper
// Revision 1.0
// ============================================================================
`default_nettype none

package matrix_scan_pkg;

  localparam logic [7:0] ROW_OFF              = 8'hFF;
  localparam logic [7:0] COL_OFF              = 8'h00;
  localparam int         DEFAULT_DWELL_CYCLES = 50000;
  localparam int         DEFAULT_BLANK_CYCLES = 500;
  localparam int         TIMER_W              = 20;

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_t;

  // Row r pulls column-select bit (7-r) low; all other rows stay off.
  function automatic logic [7:0] row_select(input logic [2:0] row);
    return ~(8'h80 >> row);
  endfunction

endpackage

`default_nettype wire

// File: rtl/matrix_scan_timer.sv
// ============================================================================
// scan_timer : up-counter that pulses done on the last cycle of a period
// Revision 1.0
// ============================================================================
`default_nettype none

module scan_timer
  import matrix_scan_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic [TIMER_W-1:0] load_val,
  output logic               done
);

  logic [TIMER_W-1:0] r_cnt;

  // The period length may change on the cycle after done; the count restarts at zero then.
  assign done = (r_cnt == (load_val - TIMER_W'(1)));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (done) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + TIMER_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/matrix_scan.sv
// ============================================================================
// matrix_scan : 8x8 LED matrix row scanner with double-buffered frame swap
// Revision 1.0
// ============================================================================
`default_nettype none

module matrix_scan
  import matrix_scan_pkg::*;
#(
  parameter int DWELL_CYCLES = DEFAULT_DWELL_CYCLES,
  parameter int BLANK_CYCLES = DEFAULT_BLANK_CYCLES
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       wr_en,
  input  logic [2:0] wr_row,
  input  logic [7:0] wr_data,
  input  logic       swap_req,
  input  logic       disp_en,
  output logic [7:0] JA,
  output logic [7:0] JB,
  output logic       swap_ack,
  output logic       frame_end
);

  localparam logic [TIMER_W-1:0] DWELL_LEN = TIMER_W'(DWELL_CYCLES);
  localparam logic [TIMER_W-1:0] BLANK_LEN = TIMER_W'(BLANK_CYCLES);

  scan_state_t        r_state;
  logic [2:0]         r_row;
  logic [7:0]         r_front [8];
  logic [7:0]         r_back  [8];
  logic               r_swap_pend;
  logic               w_done;
  logic               w_swap;
  logic [TIMER_W-1:0] w_load_val;

  assign w_load_val = (r_state == ST_DRIVE) ? DWELL_LEN : BLANK_LEN;

  // frame_end is high during the last visible DRIVE cycle of row 7; the copy lands on that edge.
  assign w_swap = frame_end && r_swap_pend;

  scan_timer u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load_val (w_load_val),
    .done     (w_done)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= ST_BLANK;
      r_row     <= 3'd0;
      JA        <= COL_OFF;
      JB        <= ROW_OFF;
      frame_end <= 1'b0;
    end else begin
      JA        <= (r_state == ST_DRIVE && disp_en) ? r_front[r_row] : COL_OFF;
      JB        <= (r_state == ST_DRIVE) ? row_select(r_row) : ROW_OFF;
      frame_end <= (r_state == ST_DRIVE) && (r_row == 3'd7) && w_done;
      if (w_done) begin
        if (r_state == ST_BLANK) begin
          r_state <= ST_DRIVE;
        end else begin
          r_state <= ST_BLANK;
          r_row   <= r_row + 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_swap_pend <= 1'b0;
      swap_ack    <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        r_front[i] <= 8'h00;
        r_back[i]  <= 8'h00;
      end
    end else begin
      swap_ack <= w_swap;
      if (w_swap) begin
        r_front     <= r_back;
        r_swap_pend <= 1'b0;
      end else if (swap_req) begin
        r_swap_pend <= 1'b1;
      end
      if (wr_en) begin
        r_back[wr_row] <= wr_data;
      end
    end
  end

endmodule

`default_nettype wire
